// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: PC width, increment and reset address.
package fetch_pkg;

  localparam int unsigned PC_W    = 64;
  localparam int unsigned PC_INCR = 4;

  typedef logic [PC_W-1:0] addr_t;

  localparam addr_t RESET_PC = '0;

endpackage

// File: rtl/pc_reg.sv
// Parameterised N-bit program-counter flop with synchronous active-high reset to RESET_PC.
module pc_reg
  import fetch_pkg::*;
#(
  parameter int unsigned N = PC_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= N'(RESET_PC);
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: holds the PC and picks PC+4 or a branch target every cycle.
// Define FETCH_BRANCH_ALIGN_EN to force branch targets onto a word boundary.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int unsigned N = PC_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         PCSrc_F,
  input  logic [N-1:0] PCBranch_F,
  output logic [N-1:0] imem_addr_F
);

  logic [N-1:0] pc_q;
  logic [N-1:0] pc_plus4;
  logic [N-1:0] branch_eff;
  logic [N-1:0] pc_next;

  // The adder wraps modulo 2^N; there is no carry out by design.
  assign pc_plus4 = pc_q + N'(PC_INCR);

`ifdef FETCH_BRANCH_ALIGN_EN
  assign branch_eff = {PCBranch_F[N-1:2], 2'b00};
`else
  assign branch_eff = PCBranch_F;
`endif

  assign pc_next = PCSrc_F ? branch_eff : pc_plus4;

  pc_reg #(
    .N(N)
  ) u_pc_reg (
    .clk  (clk),
    .reset(reset),
    .d    (pc_next),
    .q    (pc_q)
  );

  assign imem_addr_F = pc_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage; the expected alignment result follows FETCH_BRANCH_ALIGN_EN.
module tb_fetch_stage;

  localparam int unsigned N = 64;

  logic         clk;
  logic         reset;
  logic         PCSrc_F;
  logic [N-1:0] PCBranch_F;
  logic [N-1:0] imem_addr_F;

  int total = 0;
  int bad   = 0;

  fetch_stage #(
    .N(N)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .PCSrc_F    (PCSrc_F),
    .PCBranch_F (PCBranch_F),
    .imem_addr_F(imem_addr_F)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle so outputs are sampled away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [N-1:0] exp_val;
    reset      = 1'b1;
    PCSrc_F    = 1'b1;
    PCBranch_F = 64'd500;
    exp_val    = '0;
    for (int i = 0; i < 2; i++) begin
      step();
      total++;
      if (imem_addr_F !== exp_val) begin
        bad++;
        $display("[TB] FAIL reset_edge%0d: got %h expected %h", i, imem_addr_F, exp_val);
      end
    end
  endtask

  task automatic test_sequential();
    logic [N-1:0] exp_seq [4];
    exp_seq[0] = 64'd4;
    exp_seq[1] = 64'd8;
    exp_seq[2] = 64'd12;
    exp_seq[3] = 64'd16;
    reset   = 1'b0;
    PCSrc_F = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      total++;
      if (imem_addr_F !== exp_seq[i]) begin
        bad++;
        $display("[TB] FAIL sequential%0d: got %h expected %h", i, imem_addr_F, exp_seq[i]);
      end
    end
  endtask

  task automatic test_branch();
    logic [N-1:0] exp_seq [3];
    exp_seq[0] = 64'd100;
    exp_seq[1] = 64'd104;
    exp_seq[2] = 64'd108;
    reset   = 1'b1;
    PCSrc_F = 1'b0;
    step();
    reset = 1'b0;
    step();
    step();
    total++;
    if (imem_addr_F !== 64'd8) begin
      bad++;
      $display("[TB] FAIL branch_setup: got %h expected %h", imem_addr_F, 64'd8);
    end
    PCSrc_F    = 1'b1;
    PCBranch_F = 64'd100;
    for (int i = 0; i < 3; i++) begin
      step();
      PCSrc_F = 1'b0;
      total++;
      if (imem_addr_F !== exp_seq[i]) begin
        bad++;
        $display("[TB] FAIL branch%0d: got %h expected %h", i, imem_addr_F, exp_seq[i]);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    PCSrc_F    = 1'b1;
    PCBranch_F = 64'd100;
    step();
    PCSrc_F = 1'b0;
    step();
    total++;
    if (imem_addr_F !== 64'd104) begin
      bad++;
      $display("[TB] FAIL midrun_setup: got %h expected %h", imem_addr_F, 64'd104);
    end
    reset = 1'b1;
    step();
    total++;
    if (imem_addr_F !== 64'd0) begin
      bad++;
      $display("[TB] FAIL midrun_reset: got %h expected %h", imem_addr_F, 64'd0);
    end
    reset = 1'b0;
    step();
    total++;
    if (imem_addr_F !== 64'd4) begin
      bad++;
      $display("[TB] FAIL midrun_release: got %h expected %h", imem_addr_F, 64'd4);
    end
  endtask

  task automatic test_release_into_branch();
    reset      = 1'b1;
    PCSrc_F    = 1'b1;
    PCBranch_F = 64'h40;
    step();
    reset = 1'b0;
    step();
    total++;
    if (imem_addr_F !== 64'h40) begin
      bad++;
      $display("[TB] FAIL release_branch: got %h expected %h", imem_addr_F, 64'h40);
    end
    PCSrc_F = 1'b0;
  endtask

  task automatic test_wrap();
    PCSrc_F    = 1'b1;
    PCBranch_F = 64'hFFFF_FFFF_FFFF_FFFC;
    step();
    total++;
    if (imem_addr_F !== 64'hFFFF_FFFF_FFFF_FFFC) begin
      bad++;
      $display("[TB] FAIL wrap_top: got %h expected %h", imem_addr_F, 64'hFFFF_FFFF_FFFF_FFFC);
    end
    PCSrc_F = 1'b0;
    step();
    total++;
    if (imem_addr_F !== 64'd0) begin
      bad++;
      $display("[TB] FAIL wrap_zero: got %h expected %h", imem_addr_F, 64'd0);
    end
    step();
    total++;
    if (imem_addr_F !== 64'd4) begin
      bad++;
      $display("[TB] FAIL wrap_four: got %h expected %h", imem_addr_F, 64'd4);
    end
  endtask

  task automatic test_branch_hold();
    PCSrc_F    = 1'b1;
    PCBranch_F = 64'h200;
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (imem_addr_F !== 64'h200) begin
        bad++;
        $display("[TB] FAIL branch_hold%0d: got %h expected %h", i, imem_addr_F, 64'h200);
      end
    end
    PCSrc_F = 1'b0;
  endtask

  task automatic test_alignment();
    logic [N-1:0] exp_tgt;
    logic [N-1:0] exp_next;
`ifdef FETCH_BRANCH_ALIGN_EN
    exp_tgt  = 64'h100;
    exp_next = 64'h104;
`else
    exp_tgt  = 64'h103;
    exp_next = 64'h107;
`endif
    PCSrc_F    = 1'b1;
    PCBranch_F = 64'h103;
    step();
    total++;
    if (imem_addr_F !== exp_tgt) begin
      bad++;
      $display("[TB] FAIL align_target: got %h expected %h", imem_addr_F, exp_tgt);
    end
    PCSrc_F = 1'b0;
    step();
    total++;
    if (imem_addr_F !== exp_next) begin
      bad++;
      $display("[TB] FAIL align_next: got %h expected %h", imem_addr_F, exp_next);
    end
  endtask

  initial begin
    reset      = 1'b1;
    PCSrc_F    = 1'b0;
    PCBranch_F = '0;
    #2;
    test_reset();
    test_sequential();
    test_branch();
    test_reset_mid_run();
    test_release_into_branch();
    test_wrap();
    test_branch_hold();
    test_alignment();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
